uart_command_master: RTL and testbench
======================================

UART_COMMAND_MASTER -- requirements
Module: uart_command_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, byte width of UART frames; ADDRESS_WIDTH, default 4, register address width; RESPONSE_TIMEOUT_CYCLES, default 65535, clk cycles allowed for a response.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_type  in  2  0=REG_WRITE, 1=REG_READ, 2=ALU_WITH_OPERANDS, 3=ALU_NO_OPERANDS
- cmd_address  in  ADDRESS_WIDTH  register address
- cmd_write_data  in  DATA_WIDTH  register write data
- cmd_operand_A, cmd_operand_B  in  DATA_WIDTH  ALU operands
- cmd_ALU_function  in  4  ALU function code
- transmitter_parallel_data_valid  out  1  one-cycle byte strobe to UART transmitter
- transmitter_parallel_data  out  DATA_WIDTH  byte to transmit
- transmitter_busy_synchronized  in  1  UART transmitter busy
- receiver_parallel_data_valid_synchronized  in  1  one-cycle received-byte strobe
- receiver_parallel_data_synchronized  in  DATA_WIDTH  received byte
- response_valid  out  1  one-cycle pulse, command complete
- response_data  out  2*DATA_WIDTH  read data (zero-extended) or ALU result
- response_timeout  out  1  qualifies response_valid; response not received in time

Function
REQ-003 Command SHALL be accepted on a cycle with cmd_valid && cmd_ready; all cmd_* fields SHALL be registered at acceptance, later changes ignored.
REQ-004 Frames SHALL be, in order: REG_WRITE = 0xAA, address, write_data; REG_READ = 0xBB, address; ALU_WITH_OPERANDS = 0xCC, operand_A, operand_B, function; ALU_NO_OPERANDS = 0xDD, function; address and function zero-extended to DATA_WIDTH.
REQ-005 States SHALL be IDLE, SEND, WAIT_BUSY_HIGH, WAIT_BUSY_LOW, RECEIVE, RESPOND.
REQ-006 SEND: when transmitter_busy_synchronized=0, transmitter_parallel_data_valid SHALL be 1 for exactly one cycle with the current byte, then WAIT_BUSY_HIGH; while busy=1 SEND SHALL wait.
REQ-007 WAIT_BUSY_HIGH -> WAIT_BUSY_LOW on busy=1; WAIT_BUSY_LOW on busy=0 SHALL advance the byte index and go to SEND, or, after the last byte, to RECEIVE (REG_READ/ALU_*) or RESPOND (REG_WRITE).
REQ-008 transmitter_parallel_data SHALL hold the current frame byte in all non-IDLE states; 0 in IDLE.
REQ-009 RECEIVE SHALL expect 1 byte (REG_READ, placed in response_data[DATA_WIDTH-1:0], upper bits 0) or 2 bytes (ALU_*, first byte LSB, second byte MSB).
REQ-010 Received strobes outside RECEIVE SHALL be discarded without effect.
REQ-011 Timeout counter SHALL clear on entering RECEIVE, increment each RECEIVE cycle, and on reaching RESPONSE_TIMEOUT_CYCLES go to RESPOND with response_timeout=1, response_data=0; a byte strobe in the same cycle SHALL take priority (byte accepted, no timeout).
REQ-012 RESPOND SHALL last one cycle: response_valid=1 (REG_WRITE: response_data=0, response_timeout=0), then IDLE; cmd_ready SHALL rise the following cycle.
REQ-013 Minimum latency acceptance-to-first-strobe SHALL be 1 cycle.

Reset
REQ-014 reset=1 at a rising clk edge SHALL force IDLE, byte index 0, counter 0, captured command 0, and all outputs 0 except cmd_ready=1 from the first cycle after reset deasserts.
REQ-015 Reset mid-frame SHALL abort with no response pulse; a partially sent frame is not completed.

Structure
REQ-016 Shared package SHALL hold frame opcodes 0xAA/0xBB/0xCC/0xDD, cmd_type encoding and state encoding, shared with the system controller.
REQ-017 One sub-module SHALL exist: uart_command_frame_builder (combinational byte select and frame length from captured command and byte index).

Verification
REQ-018 REG_WRITE addr=5 data=0x3C, busy model 10 cycles/byte -> bytes AA,05,3C; response_valid with data 0, timeout 0.
REQ-019 REG_READ addr=2, model replies 0x7E -> bytes BB,02; response_data=0x007E.
REQ-020 ALU_WITH_OPERANDS A=0x12 B=0x34 func=0, replies 0x46,0x00 -> bytes CC,12,34,00; response_data=0x0046.
REQ-021 ALU_NO_OPERANDS func=2, no reply, RESPONSE_TIMEOUT_CYCLES=50 -> response_valid, response_timeout=1, data 0 exactly 50 cycles after entering RECEIVE; stray byte before the command ignored.
REQ-022 Reset asserted after second byte of 0xCC frame -> no further strobes, no response; next command completes normally.

Source files
------------

// File: rtl/uart_command_master_pkg.sv
// uart_command_master_pkg: frame opcodes, command type codes and FSM state
// encoding shared by the UART command master and the system controller.
package uart_command_master_pkg;

    localparam logic [7:0] OPC_REG_WRITE         = 8'hAA;
    localparam logic [7:0] OPC_REG_READ          = 8'hBB;
    localparam logic [7:0] OPC_ALU_WITH_OPERANDS = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO_OPERANDS   = 8'hDD;

    localparam logic [1:0] CMD_REG_WRITE         = 2'd0;
    localparam logic [1:0] CMD_REG_READ          = 2'd1;
    localparam logic [1:0] CMD_ALU_WITH_OPERANDS = 2'd2;
    localparam logic [1:0] CMD_ALU_NO_OPERANDS   = 2'd3;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_SEND           = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY_HIGH = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY_LOW  = 3'd3;
    localparam logic [2:0] ST_RECEIVE        = 3'd4;
    localparam logic [2:0] ST_RESPOND        = 3'd5;

    // Number of bytes in the request frame for a command type.
    function automatic logic [2:0] frame_length(input logic [1:0] cmd_type);
        logic [2:0] len;
        unique case (cmd_type)
            CMD_REG_WRITE:         len = 3'd3;
            CMD_REG_READ:          len = 3'd2;
            CMD_ALU_WITH_OPERANDS: len = 3'd4;
            default:               len = 3'd2;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/uart_command_frame_builder.sv
// uart_command_frame_builder: selects the request-frame byte for a byte
// index and reports the frame length of the captured command.
// Ports: cmd_*_i captured command, byte_index_i, frame_byte_o, frame_length_o.
module uart_command_frame_builder
    import uart_command_master_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic [1:0]               cmd_type_i,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address_i,
    input  logic [DATA_WIDTH-1:0]    cmd_write_data_i,
    input  logic [DATA_WIDTH-1:0]    cmd_operand_a_i,
    input  logic [DATA_WIDTH-1:0]    cmd_operand_b_i,
    input  logic [3:0]               cmd_function_i,
    input  logic [1:0]               byte_index_i,
    output logic [DATA_WIDTH-1:0]    frame_byte_o,
    output logic [2:0]               frame_length_o
);

    logic [DATA_WIDTH-1:0] addr_ext;
    logic [DATA_WIDTH-1:0] func_ext;

    assign addr_ext       = DATA_WIDTH'(cmd_address_i);
    assign func_ext       = DATA_WIDTH'(cmd_function_i);
    assign frame_length_o = frame_length(cmd_type_i);

    always_comb begin
        frame_byte_o = '0;
        unique case (cmd_type_i)
            CMD_REG_WRITE: begin
                case (byte_index_i)
                    2'd0:    frame_byte_o = DATA_WIDTH'(OPC_REG_WRITE);
                    2'd1:    frame_byte_o = addr_ext;
                    default: frame_byte_o = cmd_write_data_i;
                endcase
            end
            CMD_REG_READ: begin
                case (byte_index_i)
                    2'd0:    frame_byte_o = DATA_WIDTH'(OPC_REG_READ);
                    default: frame_byte_o = addr_ext;
                endcase
            end
            CMD_ALU_WITH_OPERANDS: begin
                case (byte_index_i)
                    2'd0:    frame_byte_o = DATA_WIDTH'(OPC_ALU_WITH_OPERANDS);
                    2'd1:    frame_byte_o = cmd_operand_a_i;
                    2'd2:    frame_byte_o = cmd_operand_b_i;
                    default: frame_byte_o = func_ext;
                endcase
            end
            default: begin
                case (byte_index_i)
                    2'd0:    frame_byte_o = DATA_WIDTH'(OPC_ALU_NO_OPERANDS);
                    default: frame_byte_o = func_ext;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/uart_command_master.sv
// uart_command_master: serialises register/ALU commands into UART frames,
// paces bytes on transmitter busy, collects the reply and reports a response.
// Ports: cmd_* request (valid/ready), transmitter_* byte strobe and busy,
// receiver_* reply bytes, response_valid/data/timeout completion pulse.
module uart_command_master
    import uart_command_master_pkg::*;
#(
    parameter int DATA_WIDTH              = 8,
    parameter int ADDRESS_WIDTH           = 4,
    parameter int RESPONSE_TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_type,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_address,
    input  logic [DATA_WIDTH-1:0]     cmd_write_data,
    input  logic [DATA_WIDTH-1:0]     cmd_operand_A,
    input  logic [DATA_WIDTH-1:0]     cmd_operand_B,
    input  logic [3:0]                cmd_ALU_function,
    output logic                      transmitter_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]     transmitter_parallel_data,
    input  logic                      transmitter_busy_synchronized,
    input  logic                      receiver_parallel_data_valid_synchronized,
    input  logic [DATA_WIDTH-1:0]     receiver_parallel_data_synchronized,
    output logic                      response_valid,
    output logic [2*DATA_WIDTH-1:0]   response_data,
    output logic                      response_timeout
);

    // One spare bit so the count cannot wrap after a byte lands on the limit.
    localparam int CNT_W = $clog2(RESPONSE_TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RESPONSE_TIMEOUT_CYCLES);

    logic [2:0]                state_q, state_d;
    logic [1:0]                type_q;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q, opa_q, opb_q;
    logic [3:0]                func_q;
    logic [1:0]                idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                      rx_cnt_q, rx_cnt_d;
    logic [2*DATA_WIDTH-1:0]   resp_q, resp_d;
    logic                      timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0]     frame_byte;
    logic [2:0]                frame_len;
    logic                      accept, last_byte, busy, rx_stb;
    logic [DATA_WIDTH-1:0]     rx_byte;

    uart_command_frame_builder #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_frame_builder (
        .cmd_type_i       (type_q),
        .cmd_address_i    (addr_q),
        .cmd_write_data_i (wdata_q),
        .cmd_operand_a_i  (opa_q),
        .cmd_operand_b_i  (opb_q),
        .cmd_function_i   (func_q),
        .byte_index_i     (idx_q),
        .frame_byte_o     (frame_byte),
        .frame_length_o   (frame_len)
    );

    assign busy      = transmitter_busy_synchronized;
    assign rx_stb    = receiver_parallel_data_valid_synchronized;
    assign rx_byte   = receiver_parallel_data_synchronized;
    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign last_byte = ({1'b0, idx_q} == (frame_len - 3'd1));
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rx_cnt_d  = rx_cnt_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SEND;
                    idx_d     = 2'd0;
                    rx_cnt_d  = 1'b0;
                    resp_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (!busy) state_d = ST_WAIT_BUSY_HIGH;
            end
            ST_WAIT_BUSY_HIGH: begin
                if (busy) state_d = ST_WAIT_BUSY_LOW;
            end
            ST_WAIT_BUSY_LOW: begin
                if (!busy) begin
                    if (!last_byte) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end else if (type_q == CMD_REG_WRITE) begin
                        state_d = ST_RESPOND;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_RECEIVE;
                    end
                end
            end
            ST_RECEIVE: begin
                cnt_d = cnt_inc;
                // A byte arriving on the limit cycle wins over the timeout.
                if (rx_stb) begin
                    if (type_q == CMD_REG_READ) begin
                        resp_d  = {{DATA_WIDTH{1'b0}}, rx_byte};
                        state_d = ST_RESPOND;
                    end else if (!rx_cnt_q) begin
                        resp_d[DATA_WIDTH-1:0] = rx_byte;
                        rx_cnt_d = 1'b1;
                    end else begin
                        resp_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_byte;
                        state_d = ST_RESPOND;
                    end
                end else if (cnt_inc >= CNT_LIMIT) begin
                    resp_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            type_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            func_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rx_cnt_q  <= 1'b0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            if (accept) begin
                type_q  <= cmd_type;
                addr_q  <= cmd_address;
                wdata_q <= cmd_write_data;
                opa_q   <= cmd_operand_A;
                opb_q   <= cmd_operand_B;
                func_q  <= cmd_ALU_function;
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign transmitter_parallel_data_valid = (state_q == ST_SEND) && !busy;
    assign transmitter_parallel_data = (state_q == ST_IDLE) ? '0 : frame_byte;
    assign response_valid   = (state_q == ST_RESPOND);
    assign response_data    = response_valid ? resp_q : '0;
    assign response_timeout = response_valid && timeout_q;

endmodule

// File: tb/tb_uart_command_master.sv
// tb_uart_command_master: directed vector table plus randomized commands
// against a frame/response reference model; UART busy and reply modelled here.
module tb_uart_command_master;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int TO       = 50;
    localparam int BUSY_CYC = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_write_data, cmd_operand_A, cmd_operand_B;
    logic [3:0]    cmd_ALU_function;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          busy;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          response_valid;
    logic [2*DW-1:0] response_data;
    logic          response_timeout;

    always #5 clk = ~clk;

    uart_command_master #(
        .DATA_WIDTH              (DW),
        .ADDRESS_WIDTH           (AW),
        .RESPONSE_TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                                       (clk),
        .reset                                     (reset),
        .cmd_valid                                 (cmd_valid),
        .cmd_ready                                 (cmd_ready),
        .cmd_type                                  (cmd_type),
        .cmd_address                               (cmd_address),
        .cmd_write_data                            (cmd_write_data),
        .cmd_operand_A                             (cmd_operand_A),
        .cmd_operand_B                             (cmd_operand_B),
        .cmd_ALU_function                          (cmd_ALU_function),
        .transmitter_parallel_data_valid           (tx_valid),
        .transmitter_parallel_data                 (tx_data),
        .transmitter_busy_synchronized             (busy),
        .receiver_parallel_data_valid_synchronized (rx_valid),
        .receiver_parallel_data_synchronized       (rx_data),
        .response_valid                            (response_valid),
        .response_data                             (response_data),
        .response_timeout                          (response_timeout)
    );

    typedef struct {
        string          name;
        logic [1:0]     typ;
        logic [3:0]     addr;
        logic [7:0]     wdata, a, b;
        logic [3:0]     func;
        int             nrep;
        logic [7:0]     r0, r1;
        logic           stray;
        int             len;
        logic [3:0][7:0] eb;
        logic [15:0]    edata;
        logic           eto;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        to;
        time         t;
    } resp_t;

    logic [7:0] tx_q[$];
    resp_t      resp_q[$];
    int         busy_cnt;
    logic       arm;
    time        t_fall;
    int         errors = 0;
    int         checks = 0;
    vec_t       vecs[7];

    // UART transmitter model: busy rises the cycle after a strobe and
    // stays high for BUSY_CYC cycles; every strobed byte is recorded.
    initial begin
        busy = 1'b0; busy_cnt = 0; arm = 1'b0; t_fall = 0;
        forever begin
            logic s;
            @(negedge clk);
            s = tx_valid;
            if (reset) begin
                busy = 1'b0; busy_cnt = 0; arm = 1'b0;
            end else begin
                if (s) tx_q.push_back(tx_data);
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        busy = 1'b0;
                        t_fall = $time;
                    end
                end
                if (arm) begin
                    busy_cnt = BUSY_CYC; busy = 1'b1; arm = 1'b0;
                end
                if (s) arm = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            resp_t r;
            @(negedge clk);
            if (response_valid) begin
                r.data = response_data;
                r.to   = response_timeout;
                r.t    = $time;
                resp_q.push_back(r);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(string name, logic [1:0] typ, logic [3:0] addr,
                                logic [7:0] wdata, logic [7:0] a, logic [7:0] b,
                                logic [3:0] func, int nrep, logic [7:0] r0,
                                logic [7:0] r1, logic stray, int len,
                                logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                logic [7:0] b3, logic [15:0] edata, logic eto);
        vec_t v;
        v.name = name; v.typ = typ; v.addr = addr; v.wdata = wdata;
        v.a = a; v.b = b; v.func = func; v.nrep = nrep; v.r0 = r0; v.r1 = r1;
        v.stray = stray; v.len = len; v.eb = {b3, b2, b1, b0};
        v.edata = edata; v.eto = eto;
        return v;
    endfunction

    // Reference: frame bytes and expected response from the command alone.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r;
        int need;
        r = v;
        need = 0;
        r.eb = '0;
        case (v.typ)
            2'd0: begin
                r.len = 3; r.eb[0] = 8'hAA; r.eb[1] = {4'h0, v.addr};
                r.eb[2] = v.wdata; need = 0;
            end
            2'd1: begin
                r.len = 2; r.eb[0] = 8'hBB; r.eb[1] = {4'h0, v.addr}; need = 1;
            end
            2'd2: begin
                r.len = 4; r.eb[0] = 8'hCC; r.eb[1] = v.a; r.eb[2] = v.b;
                r.eb[3] = {4'h0, v.func}; need = 2;
            end
            default: begin
                r.len = 2; r.eb[0] = 8'hDD; r.eb[1] = {4'h0, v.func}; need = 2;
            end
        endcase
        r.eto = (v.nrep < need);
        if (r.eto || need == 0) r.edata = 16'h0000;
        else if (need == 1)     r.edata = {8'h00, v.r0};
        else                    r.edata = {v.r1, v.r0};
        return r;
    endfunction

    task automatic scramble();
        cmd_type         = 2'($urandom_range(0, 3));
        cmd_address      = 4'($urandom_range(0, 15));
        cmd_write_data   = 8'($urandom_range(0, 255));
        cmd_operand_A    = 8'($urandom_range(0, 255));
        cmd_operand_B    = 8'($urandom_range(0, 255));
        cmd_ALU_function = 4'($urandom_range(0, 15));
    endtask

    task automatic run_cmd(input vec_t v);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        chk({v.name, " ready_before"}, cmd_ready, 1);
        if (v.stray) begin
            rx_valid = 1'b1; rx_data = 8'h99; tick();
            rx_valid = 1'b0; tick();
        end
        tx_q.delete();
        resp_q.delete();
        cmd_type = v.typ; cmd_address = v.addr; cmd_write_data = v.wdata;
        cmd_operand_A = v.a; cmd_operand_B = v.b; cmd_ALU_function = v.func;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        scramble();
        chk({v.name, " first_strobe_latency"}, tx_valid, 1);
        chk({v.name, " first_byte"}, tx_data, v.eb[0]);
        n = 0;
        while (!(tx_q.size() >= v.len && !busy && !arm) && n < 400) begin
            tick(); n++;
        end
        chk({v.name, " frame_done_in_time"}, n < 400, 1);
        for (int i = 0; i < v.nrep; i++) begin
            rx_valid = 1'b1;
            rx_data  = (i == 0) ? v.r0 : v.r1;
            tick();
            rx_valid = 1'b0;
            if (i + 1 < v.nrep) tick();
        end
        n = 0;
        while (resp_q.size() == 0 && n < 200) begin tick(); n++; end
        chk({v.name, " response_seen"}, resp_q.size() > 0, 1);
        chk({v.name, " tx_count"}, tx_q.size(), v.len);
        for (int i = 0; i < v.len && i < tx_q.size(); i++)
            chk($sformatf("%s byte%0d", v.name, i), tx_q[i], v.eb[i]);
        if (resp_q.size() == 0) return;
        chk({v.name, " cmd_ready_after"}, cmd_ready, 1);
        chk({v.name, " response_data"}, resp_q[0].data, v.edata);
        chk({v.name, " response_timeout"}, resp_q[0].to, v.eto);
        if (v.eto)
            chk({v.name, " timeout_cycles"},
                32'(int'((resp_q[0].t - t_fall) / 10) - 1), TO);
        repeat (3) tick();
        chk({v.name, " single_response"}, resp_q.size(), 1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; rx_valid = 1'b0; rx_data = '0;
        cmd_type = '0; cmd_address = '0; cmd_write_data = '0;
        cmd_operand_A = '0; cmd_operand_B = '0; cmd_ALU_function = '0;

        vecs[0] = mk("reg_write", 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0,
                     8'h00, 8'h00, 1'b0, 3, 8'hAA, 8'h05, 8'h3C, 8'h00,
                     16'h0000, 1'b0);
        vecs[1] = mk("reg_read", 2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1,
                     8'h7E, 8'h00, 1'b0, 2, 8'hBB, 8'h02, 8'h00, 8'h00,
                     16'h007E, 1'b0);
        vecs[2] = mk("alu_ops", 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 2,
                     8'h46, 8'h00, 1'b0, 4, 8'hCC, 8'h12, 8'h34, 8'h00,
                     16'h0046, 1'b0);
        vecs[3] = mk("alu_noops_timeout", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00,
                     4'h2, 0, 8'h00, 8'h00, 1'b1, 2, 8'hDD, 8'h02, 8'h00,
                     8'h00, 16'h0000, 1'b1);
        vecs[4] = mk("reg_write_max", 2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0,
                     0, 8'h00, 8'h00, 1'b0, 3, 8'hAA, 8'h0F, 8'hFF, 8'h00,
                     16'h0000, 1'b0);
        vecs[5] = mk("alu_noops_reply", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF,
                     2, 8'hA5, 8'h5A, 1'b0, 2, 8'hDD, 8'h0F, 8'h00, 8'h00,
                     16'h5AA5, 1'b0);
        vecs[6] = mk("alu_ops_partial", 2'd2, 4'h0, 8'h00, 8'hF0, 8'h0F, 4'h7,
                     1, 8'h33, 8'h00, 1'b0, 4, 8'hCC, 8'hF0, 8'h0F, 8'h07,
                     16'h0000, 1'b1);

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        tick();
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset response_valid", response_valid, 0);
        chk("reset response_data", response_data, 0);
        chk("reset response_timeout", response_timeout, 0);

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        begin
            int n;
            tx_q.delete();
            cmd_type = 2'd2; cmd_operand_A = 8'h11; cmd_operand_B = 8'h22;
            cmd_ALU_function = 4'h3; cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            n = 0;
            while (tx_q.size() < 2 && n < 200) begin tick(); n++; end
            chk("midframe two_bytes_sent", tx_q.size(), 2);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            resp_q.delete();
            chk("midframe cmd_ready", cmd_ready, 1);
            chk("midframe tx_data", tx_data, 0);
            repeat (80) tick();
            chk("midframe no_more_strobes", tx_q.size(), 2);
            chk("midframe no_response", resp_q.size(), 0);
            run_cmd(vecs[1]);
        end

        for (int k = 0; k < 25; k++) begin
            vec_t v;
            int need;
            v.name  = $sformatf("random%0d", k);
            v.typ   = 2'($urandom_range(0, 3));
            v.addr  = 4'($urandom_range(0, 15));
            v.wdata = 8'($urandom_range(0, 255));
            v.a     = 8'($urandom_range(0, 255));
            v.b     = 8'($urandom_range(0, 255));
            v.func  = 4'($urandom_range(0, 15));
            v.r0    = 8'($urandom_range(0, 255));
            v.r1    = 8'($urandom_range(0, 255));
            v.stray = ($urandom_range(0, 4) == 0);
            need = (v.typ == 2'd0) ? 0 : (v.typ == 2'd1) ? 1 : 2;
            if (need > 0 && $urandom_range(0, 3) == 0)
                v.nrep = int'($urandom_range(0, need - 1));
            else
                v.nrep = need;
            run_cmd(ref_model(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
